if_id_fifo: RTL and testbench

Parametrised instruction queue between the fetch (IF) and decode (ID) stages, replacing the single-entry IF/ID register. Fetch pushes (pc, instruction) pairs under a valid/ready handshake; decode consumes the head entry unless the ID stall bit is set. Pipeline flush discards all queued entries. The block lets IF run ahead of ID by up to DEPTH instructions and presents a NOP bubble to ID whenever the queue is empty.

---
 rtl/if_id_fifo.sv | 95 +++++++++
 tb/tb_if_id_fifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/if_id_fifo.sv
// IF/ID instruction queue: lets fetch run up to DEPTH entries ahead of decode.
// An empty queue presents a zero (NOP) bubble on the ID side.
module if_id_fifo #(
  parameter  int PC_W         = 32,
  parameter  int INST_W       = 32,
  parameter  int DEPTH        = 4,
  parameter  int STALL_W      = 6,
  parameter  int ID_STALL_BIT = 2,
  localparam int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               if_valid,
  input  logic [PC_W-1:0]    if_pc,
  input  logic [INST_W-1:0]  if_inst,
  output logic               if_ready,
  output logic               id_valid,
  output logic [PC_W-1:0]    id_pc,
  output logic [INST_W-1:0]  id_inst,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               push;
  logic               pop;
  logic               id_stall;
  entry_t             head;

  // Only the ID bit of the stall vector matters here.
  logic               stall_unused;
  assign stall_unused = ^stall;
  assign id_stall     = stall[ID_STALL_BIT];

  assign if_ready = (cnt_q != FULL_CNT) && !flush && !rst;
  assign id_valid = (cnt_q != '0);
  assign push     = if_valid && if_ready;
  assign pop      = id_valid && !id_stall;

  assign head     = mem_q[rd_q];
  assign id_pc    = id_valid ? head.pc   : '0;
  assign id_inst  = id_valid ? head.inst : '0;
  assign count    = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      wr_d = wr_q + PTR_W'(push);
      rd_d = rd_q + PTR_W'(pop);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage is never cleared; id_valid masks stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= '{pc: if_pc, inst: if_inst};
    end
  end

endmodule

// File: tb/tb_if_id_fifo.sv
// Randomised bench for if_id_fifo against a queue-based reference model.
// Directed phases mirror the intended use cases, then random traffic.
module tb_if_id_fifo;

  localparam int PC_W    = 32;
  localparam int INST_W  = 32;
  localparam int DEPTH   = 4;
  localparam int STALL_W = 6;
  localparam int IDB     = 2;
  localparam int CNT_W   = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               if_valid;
  logic [PC_W-1:0]    if_pc;
  logic [INST_W-1:0]  if_inst;
  logic               if_ready;
  logic               id_valid;
  logic [PC_W-1:0]    id_pc;
  logic [INST_W-1:0]  id_inst;
  logic [CNT_W-1:0]   count;

  always #5 clk = ~clk;

  if_id_fifo #(
    .PC_W(PC_W), .INST_W(INST_W), .DEPTH(DEPTH),
    .STALL_W(STALL_W), .ID_STALL_BIT(IDB)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_ready(if_ready), .id_valid(id_valid),
    .id_pc(id_pc), .id_inst(id_inst), .count(count)
  );

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ent_t;

  ent_t mq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)",
               tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, check outputs, let model follow the edge.
  task automatic cyc(input logic r, input logic [STALL_W-1:0] st,
                     input logic fl, input logic v,
                     input logic [PC_W-1:0] pc,
                     input logic [INST_W-1:0] in,
                     input bit check, output bit acc);
    bit   e_rdy;
    bit   e_vld;
    ent_t e;
    @(negedge clk);
    rst = r; stall = st; flush = fl;
    if_valid = v; if_pc = pc; if_inst = in;
    #1;
    e_rdy = (mq.size() < DEPTH) && !fl && !r;
    e_vld = (mq.size() > 0);
    e.pc   = e_vld ? mq[0].pc   : '0;
    e.inst = e_vld ? mq[0].inst : '0;
    if (check) begin
      chk("count",    64'(count),    64'(mq.size()));
      chk("if_ready", 64'(if_ready), 64'(e_rdy));
      chk("id_valid", 64'(id_valid), 64'(e_vld));
      chk("id_pc",    64'(id_pc),    64'(e.pc));
      chk("id_inst",  64'(id_inst),  64'(e.inst));
    end
    acc = v && e_rdy;
    @(posedge clk);
    if (r || fl) begin
      mq.delete();
    end else begin
      if (e_vld && !st[IDB]) void'(mq.pop_front());
      if (acc) mq.push_back('{pc: pc, inst: in});
    end
  endtask

  task automatic idle(input logic [STALL_W-1:0] st);
    bit a;
    cyc(1'b0, st, 1'b0, 1'b0, '0, '0, 1'b1, a);
  endtask

  localparam logic [STALL_W-1:0] S_ID = 6'b000100;

  initial begin
    bit a;
    int pushed;
    int t;
    logic [PC_W-1:0] pcv;

    // Reset held two cycles with IF offering; first cycle state is unknown.
    cyc(1'b1, '0, 1'b0, 1'b1, 32'hDEAD_0000, 32'h1, 1'b0, a);
    cyc(1'b1, '0, 1'b0, 1'b1, 32'hDEAD_0004, 32'h2, 1'b1, a);
    idle('0);
    idle('0);

    // Streaming with ID never stalled.
    for (int i = 0; i < 8; i++)
      cyc(1'b0, '0, 1'b0, 1'b1, 32'(4 * i), 32'h2400_0001 + 32'(i),
          1'b1, a);
    idle('0);
    idle('0);

    // Fill to full while ID is stalled, fifth entry held.
    for (int i = 0; i < 5; i++)
      cyc(1'b0, S_ID, 1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'(i),
          1'b1, a);
    cyc(1'b0, S_ID, 1'b0, 1'b1, 32'h110, 32'h4, 1'b1, a);
    pushed = 0;
    t = 0;
    a = 0;
    while (!a && t < 10) begin
      cyc(1'b0, '0, 1'b0, 1'b1, 32'h110, 32'h4, 1'b1, a);
      t++;
    end
    chk("fifth_accept_cycle", 64'(t), 64'd2);
    repeat (6) idle('0);

    // Wrap-around: ID stall toggles every 3 cycles.
    pushed = 0;
    t = 0;
    while (pushed < 10 && t < 100) begin
      pcv = 32'h200 + 32'(4 * pushed);
      cyc(1'b0, ((t / 3) % 2 == 0) ? S_ID : '0, 1'b0, 1'b1,
          pcv, 32'hA000 + 32'(pushed), 1'b1, a);
      if (a) pushed++;
      t++;
    end
    chk("wrap_pushes", 64'(pushed), 64'd10);
    repeat (6) idle('0);

    // Flush at occupancy 3 with a concurrent offer.
    for (int i = 0; i < 3; i++)
      cyc(1'b0, S_ID, 1'b0, 1'b1, 32'h300 + 32'(4 * i), 32'(i),
          1'b1, a);
    cyc(1'b0, '0, 1'b1, 1'b1, 32'h3FC, 32'hBAD, 1'b1, a);
    idle('0);
    cyc(1'b0, '0, 1'b0, 1'b1, 32'h400, 32'h4000, 1'b1, a);
    idle('0);
    idle('0);

    // Non-ID stall bits must not block pops.
    for (int i = 0; i < 3; i++)
      cyc(1'b0, S_ID, 1'b0, 1'b1, 32'h500 + 32'(4 * i), 32'(i),
          1'b1, a);
    repeat (4) idle(6'b111011);

    // Random traffic including mid-stream flush and reset.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 63) == 0,
          6'($urandom),
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 3) != 0,
          $urandom, $urandom, 1'b1, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
